bus_slot_scheduler: RTL and testbench
=====================================

# bus_slot_scheduler

Time-slot scheduler for the shared Wishbone/RAM bus. Divides each 1 MHz CPU cycle into eight 8-clock slots and assigns each slot to the CPU, the video fetch controller, or the SPI1 bridge. It forwards the slot owner's Wishbone requests to the shared bus and routes the acknowledgements back. It drives `cpu_grant_en_o` to the CPU sequencer and guarantees that no Wishbone transfer is outstanding while the CPU owns the bus.

## Interface
Parameters:
- `WB_ADDR_WIDTH`, 17: Wishbone address width.
- `DATA_WIDTH`, 8: data width.
- `CPU_SLOT_MASK`, 8'b1111_0000: bit s set means slot s belongs to the CPU.
- `VIDEO_SLOT_MASK`, 8'b0000_0011: bit s set means video has priority in slot s. Must not overlap `CPU_SLOT_MASK`.
- `GUARD_CYCLES`, 4: number of final clocks of a slot in which no new strobe is accepted (1..7).

Ports:
- `sys_clock_i`  in  1  64 MHz system clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `clk8_en_i`  in  1  one-clock pulse every 8 clocks; marks a slot boundary.
- `spi1_addr_i`, `spi1_data_i`, `spi1_we_i`, `spi1_cycle_i`, `spi1_strobe_i`  in  WB_ADDR_WIDTH/DATA_WIDTH/1/1/1  SPI1 requester.
- `spi1_stall_o`, `spi1_ack_o`  out  1/1  SPI1 handshake.
- `video_addr_i`, `video_data_i`, `video_we_i`, `video_cycle_i`, `video_strobe_i`  in  same widths  video requester.
- `video_stall_o`, `video_ack_o`  out  1/1  video handshake.
- `wb_addr_o`, `wb_data_o`, `wb_we_o`, `wb_cycle_o`, `wb_strobe_o`  out  WB_ADDR_WIDTH/DATA_WIDTH/1/1/1  shared bus.
- `wb_stall_i`, `wb_ack_i`  in  1/1  shared bus handshake.
- `cpu_grant_en_o`  out  1  CPU owns the bus this clock.
- `overrun_o`  out  1  sticky: a transfer was still outstanding at a slot boundary.
- `overrun_clr_i`  in  1  clears `overrun_o`.

## Operation
- `slot` (3 bits) increments on `clk8_en_i` and wraps from 7 to 0. `pos` (3 bits) resets to 0 on `clk8_en_i` and otherwise increments, saturating at 7.
- Owner per slot:
  - CPU if `CPU_SLOT_MASK[slot]`.
  - Otherwise video if `VIDEO_SLOT_MASK[slot]` and `video_cycle_i`.
  - Otherwise SPI1. Unused video slots are donated to SPI1. CPU slots are never donated.
- Owner is registered at the boundary: it is computed from `slot+1` and `video_cycle_i` on the `clk8_en_i` clock.
- Accept window: `pos < 8-GUARD_CYCLES` and the state is IDLE.
- State machine:
  - IDLE→BUSY when the owner's `strobe & !stall`.
  - BUSY→IDLE on `wb_ack_i`. The ack is forwarded only to the owner that issued the transfer (owner latched at strobe).
  - Exactly one transfer is allowed per requester per slot. After it completes, the requester stays stalled until the slot ends.
- Mux: `wb_addr/data/we/cycle_o` come from the owner when the owner is a Wishbone requester.
  - `wb_strobe_o` = owner strobe AND accept window AND not yet used this slot.
  - `wb_cycle_o` stays high throughout BUSY.
  - When the CPU owns the bus, `wb_cycle_o` and `wb_strobe_o` are 0.
- Stall: a requester's stall = !(is owner AND accept window AND unused AND !`wb_stall_i`). A non-owner always sees stall=1.
- `cpu_grant_en_o` is 1 when the owner is the CPU and the state is IDLE.
- Overrun: a slot boundary reached while BUSY sets `overrun_o`. The state stays BUSY and ownership still advances.
  - If the next owner is the CPU, `cpu_grant_en_o` is held at 0 until the ack arrives.
  - If the next owner is a Wishbone requester, it stays stalled until the ack arrives.
  - If set and clear occur in the same clock, set wins.

## Timing
- Reset values:
  - `slot`=0, `pos`=0, owner=NONE, state=IDLE.
  - All `wb_*_o`=0, `cpu_grant_en_o`=0, `overrun_o`=0.
  - `*_stall_o`=1, `*_ack_o`=0.
- Ownership is valid from the clock after the first `clk8_en_i`. An asynchronous reset asserted mid-transfer drops BUSY immediately, with no ack forwarded.
- Strobe pass-through is combinational (zero latency). Stall is combinational from `wb_stall_i`.
- `*_ack_o` = `wb_ack_i` AND BUSY AND latched owner, combinational. An ack in the same clock as its strobe is ignored: the bus is pipelined and acks arrive at least 1 clock later.
- `cpu_grant_en_o` is registered: high on the clock after the boundary into a CPU slot, low on the clock after the boundary out of it.
- With default parameters, the last strobe acceptance in a slot is at `pos`=3. Any transfer acked within 4 clocks therefore never overruns.

## Test plan
- SPI1 strobes continuously, no video, defaults → exactly 2 `wb_strobe_o` pulses per 64 clocks (one in slot 2, one in slot 3) plus slots 0/1 donated, for 4 total. `cpu_grant_en_o` high only during slots 4–7.
- Video and SPI1 both request in slot 0 → video gets the strobe and ack. SPI1 sees stall=1 until slot 2, then one transfer.
- SPI1 strobe presented at `pos`=4 in slot 2 → stall held. The transfer issues at `pos`=0 of slot 3.
- Ack delayed 12 clocks on a slot-3 transfer → `overrun_o`=1 and `cpu_grant_en_o` stays 0 until the ack clock +1. A later `overrun_clr_i` pulse returns `overrun_o` to 0.
- `reset_ni` pulsed low while BUSY → all outputs return to reset values within the same clock. No ack is forwarded and the schedule restarts at slot 0.
- `wb_ack_i` asserted while IDLE → `spi1_ack_o` and `video_ack_o` stay 0.

Source files
------------

// File: rtl/bus_slot_scheduler.sv
// Time-slot scheduler for the shared Wishbone/RAM bus.
// Each 1 MHz CPU cycle is split into eight 8-clock slots. A slot belongs to the
// CPU, the video fetch controller or the SPI1 bridge. The current owner's
// Wishbone request is forwarded to the shared bus, and the acknowledge is routed
// back to the requester that issued the transfer. Each requester gets at most one
// transfer per slot. No new strobe is accepted in the final GUARD_CYCLES clocks of
// a slot.
module bus_slot_scheduler #(
    parameter int         WB_ADDR_WIDTH   = 17,
    parameter int         DATA_WIDTH      = 8,
    parameter logic [7:0] CPU_SLOT_MASK   = 8'b1111_0000,
    parameter logic [7:0] VIDEO_SLOT_MASK = 8'b0000_0011,
    parameter int         GUARD_CYCLES    = 4
) (
    input  logic                     sys_clock_i,
    input  logic                     reset_ni,
    input  logic                     clk8_en_i,
    input  logic [WB_ADDR_WIDTH-1:0] spi1_addr_i,
    input  logic [DATA_WIDTH-1:0]    spi1_data_i,
    input  logic                     spi1_we_i,
    input  logic                     spi1_cycle_i,
    input  logic                     spi1_strobe_i,
    output logic                     spi1_stall_o,
    output logic                     spi1_ack_o,
    input  logic [WB_ADDR_WIDTH-1:0] video_addr_i,
    input  logic [DATA_WIDTH-1:0]    video_data_i,
    input  logic                     video_we_i,
    input  logic                     video_cycle_i,
    input  logic                     video_strobe_i,
    output logic                     video_stall_o,
    output logic                     video_ack_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    output logic                     cpu_grant_en_o,
    output logic                     overrun_o,
    input  logic                     overrun_clr_i
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_VIDEO = 2'd2,
        OWN_SPI1  = 2'd3
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Strobes are accepted only while pos is below this limit.
    localparam logic [3:0] ACCEPT_LIMIT = 4'(8 - GUARD_CYCLES);

    logic [2:0] r_slot;
    logic [2:0] r_pos;
    owner_t     r_owner;
    state_t     r_state;
    owner_t     r_xfer_owner;
    logic       r_used;
    logic       r_cpu_grant;
    logic       r_overrun;

    logic [WB_ADDR_WIDTH-1:0] w_req_addr;
    logic [DATA_WIDTH-1:0]    w_req_data;
    logic                     w_req_we;
    logic                     w_req_cyc;
    logic                     w_req_stb;
    logic                     w_open;
    logic                     w_accept;
    logic                     w_busy;
    logic [2:0]               w_next_slot;
    owner_t                   w_next_owner;
    owner_t                   w_owner_after;
    logic                     w_idle_after;

    // CPU slots are never donated. An unused video slot falls through to SPI1.
    function automatic owner_t f_slot_owner(input logic [2:0] slot, input logic video_cycle);
        owner_t own;
        if (CPU_SLOT_MASK[slot]) begin
            own = OWN_CPU;
        end else if (VIDEO_SLOT_MASK[slot] && video_cycle) begin
            own = OWN_VIDEO;
        end else begin
            own = OWN_SPI1;
        end
        return own;
    endfunction

    assign w_busy       = (r_state == ST_BUSY);
    assign w_next_slot  = r_slot + 3'd1;
    assign w_next_owner = f_slot_owner(w_next_slot, video_cycle_i);

    // Select the current owner's Wishbone request. The CPU and NONE owners drive nothing.
    always_comb begin
        w_req_addr = {WB_ADDR_WIDTH{1'b0}};
        w_req_data = {DATA_WIDTH{1'b0}};
        w_req_we   = 1'b0;
        w_req_cyc  = 1'b0;
        w_req_stb  = 1'b0;
        case (r_owner)
            OWN_VIDEO: begin
                w_req_addr = video_addr_i;
                w_req_data = video_data_i;
                w_req_we   = video_we_i;
                w_req_cyc  = video_cycle_i;
                w_req_stb  = video_strobe_i;
            end
            OWN_SPI1: begin
                w_req_addr = spi1_addr_i;
                w_req_data = spi1_data_i;
                w_req_we   = spi1_we_i;
                w_req_cyc  = spi1_cycle_i;
                w_req_stb  = spi1_strobe_i;
            end
            default: begin
                w_req_addr = {WB_ADDR_WIDTH{1'b0}};
                w_req_data = {DATA_WIDTH{1'b0}};
                w_req_we   = 1'b0;
                w_req_cyc  = 1'b0;
                w_req_stb  = 1'b0;
            end
        endcase
    end

    // The accept window is open early in the slot, while idle, and if the owner has not yet used the slot.
    assign w_open   = (r_state == ST_IDLE) && !r_used && ({1'b0, r_pos} < ACCEPT_LIMIT);
    assign w_accept = w_req_stb && w_open && !wb_stall_i;

    assign wb_addr_o   = w_req_addr;
    assign wb_data_o   = w_req_data;
    assign wb_we_o     = w_req_we;
    assign wb_strobe_o = w_req_stb && w_open;
    assign wb_cycle_o  = w_req_cyc || w_busy;

    assign spi1_stall_o  = !((r_owner == OWN_SPI1)  && w_open && !wb_stall_i);
    assign video_stall_o = !((r_owner == OWN_VIDEO) && w_open && !wb_stall_i);

    // Acks go back only to the requester that issued the transfer. Acks seen while idle are dropped.
    assign spi1_ack_o  = wb_ack_i && w_busy && (r_xfer_owner == OWN_SPI1);
    assign video_ack_o = wb_ack_i && w_busy && (r_xfer_owner == OWN_VIDEO);

    assign cpu_grant_en_o = r_cpu_grant;
    assign overrun_o      = r_overrun;

    // Owner and idle status as they will be after this clock. Both feed the registered CPU grant.
    always_comb begin
        w_owner_after = r_owner;
        w_idle_after  = 1'b0;
        if (clk8_en_i) begin
            w_owner_after = w_next_owner;
        end else begin
            w_owner_after = r_owner;
        end
        if (r_state == ST_IDLE) begin
            w_idle_after = !w_accept;
        end else begin
            w_idle_after = wb_ack_i;
        end
    end

    // Slot counter, position within the slot, and owner registered at each slot boundary.
    always_ff @(posedge sys_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_slot  <= 3'd0;
            r_pos   <= 3'd0;
            r_owner <= OWN_NONE;
        end else if (clk8_en_i) begin
            r_slot  <= w_next_slot;
            r_pos   <= 3'd0;
            r_owner <= w_next_owner;
        end else if (r_pos != 3'd7) begin
            r_pos   <= r_pos + 3'd1;
        end
    end

    // Transfer FSM, one-per-slot bookkeeping, CPU grant and sticky overrun flag.
    always_ff @(posedge sys_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_xfer_owner <= OWN_NONE;
            r_used       <= 1'b0;
            r_cpu_grant  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_BUSY;
                        r_xfer_owner <= r_owner;
                    end
                end
                ST_BUSY: begin
                    if (wb_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (clk8_en_i) begin
                r_used <= 1'b0;
            end else if (w_accept) begin
                r_used <= 1'b1;
            end

            r_cpu_grant <= (w_owner_after == OWN_CPU) && w_idle_after;

            // A set at a boundary takes precedence over a clear in the same clock.
            if (clk8_en_i && w_busy && !wb_ack_i) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Directed bench for bus_slot_scheduler. The bench keeps its own slot/pos
// timeline and a simple bus slave with a programmable ack delay. It also holds a
// scoreboard of expected transfers, pushed when a request is raised and popped
// when the shared bus accepts a strobe.
module tb_bus_slot_scheduler;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          sys_clock_i = 1'b0;
    logic          reset_ni;
    logic          clk8_en_i;
    logic [AW-1:0] spi1_addr_i;
    logic [DW-1:0] spi1_data_i;
    logic          spi1_we_i, spi1_cycle_i, spi1_strobe_i;
    logic          spi1_stall_o, spi1_ack_o;
    logic [AW-1:0] video_addr_i;
    logic [DW-1:0] video_data_i;
    logic          video_we_i, video_cycle_i, video_strobe_i;
    logic          video_stall_o, video_ack_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic          wb_we_o, wb_cycle_o, wb_strobe_o;
    logic          wb_stall_i, wb_ack_i;
    logic          cpu_grant_en_o, overrun_o, overrun_clr_i;

    bus_slot_scheduler dut (
        .sys_clock_i(sys_clock_i), .reset_ni(reset_ni), .clk8_en_i(clk8_en_i),
        .spi1_addr_i(spi1_addr_i), .spi1_data_i(spi1_data_i), .spi1_we_i(spi1_we_i),
        .spi1_cycle_i(spi1_cycle_i), .spi1_strobe_i(spi1_strobe_i),
        .spi1_stall_o(spi1_stall_o), .spi1_ack_o(spi1_ack_o),
        .video_addr_i(video_addr_i), .video_data_i(video_data_i), .video_we_i(video_we_i),
        .video_cycle_i(video_cycle_i), .video_strobe_i(video_strobe_i),
        .video_stall_o(video_stall_o), .video_ack_o(video_ack_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
        .wb_cycle_o(wb_cycle_o), .wb_strobe_o(wb_strobe_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
        .cpu_grant_en_o(cpu_grant_en_o), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
    );

    always #5 sys_clock_i = ~sys_clock_i;

    typedef struct {
        logic          is_vid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        int            exp_slot;
        int            exp_pos;
    } xfer_t;

    xfer_t sb_q[$];

    int   total = 0;
    int   bad   = 0;
    int   ph, slot_m, ack_cnt, ack_delay, n_acc;
    bit   valid_m, chk_grant, spi_cont;
    logic last_vid;
    logic [7:0] cpu_mask = 8'b1111_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic is_vid, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic we, input int exp_slot, input int exp_pos);
        xfer_t e;
        e.is_vid = is_vid; e.addr = addr; e.data = data; e.we = we;
        e.exp_slot = exp_slot; e.exp_pos = exp_pos;
        sb_q.push_back(e);
    endtask

    task automatic check_reset();
        check("rst_wb_addr",   32'(wb_addr_o), 32'd0);
        check("rst_wb_data",   32'(wb_data_o), 32'd0);
        check("rst_wb_we",     32'(wb_we_o), 32'd0);
        check("rst_wb_cycle",  32'(wb_cycle_o), 32'd0);
        check("rst_wb_strobe", 32'(wb_strobe_o), 32'd0);
        check("rst_grant",     32'(cpu_grant_en_o), 32'd0);
        check("rst_overrun",   32'(overrun_o), 32'd0);
        check("rst_spi_stall", 32'(spi1_stall_o), 32'd1);
        check("rst_vid_stall", 32'(video_stall_o), 32'd1);
        check("rst_spi_ack",   32'(spi1_ack_o), 32'd0);
        check("rst_vid_ack",   32'(video_ack_o), 32'd0);
    endtask

    task automatic release_reset();
        reset_ni  = 1'b1;
        wb_ack_i  = 1'b0;
        clk8_en_i = 1'b0;
        ph = 0; slot_m = 0; valid_m = 1'b0; ack_cnt = 0;
    endtask

    // One clock: sample handshakes before the edge, then advance the timeline, the slave and the requesters.
    task automatic tick();
        xfer_t e;
        logic acc_spi, acc_vid, acc_wb;
        #1;
        acc_spi = spi1_strobe_i && !spi1_stall_o;
        acc_vid = video_strobe_i && !video_stall_o;
        acc_wb  = wb_strobe_o && !wb_stall_i;
        if (acc_wb) begin
            n_acc++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr", 32'(wb_addr_o), 32'(e.addr));
                check("sb_data", 32'(wb_data_o), 32'(e.data));
                check("sb_we",   32'(wb_we_o), 32'(e.we));
                check("sb_vid_grant", 32'(acc_vid), 32'(e.is_vid));
                check("sb_spi_grant", 32'(acc_spi), 32'(!e.is_vid));
                if (e.exp_slot >= 0) check("sb_slot", 32'(slot_m), 32'(e.exp_slot));
                if (e.exp_pos >= 0)  check("sb_pos", 32'(ph), 32'(e.exp_pos));
                last_vid = e.is_vid;
            end
        end
        if (wb_ack_i) begin
            check("ack_spi", 32'(spi1_ack_o), 32'(!last_vid));
            check("ack_vid", 32'(video_ack_o), 32'(last_vid));
        end
        @(posedge sys_clock_i);
        #1;
        if (clk8_en_i) begin
            slot_m  = (slot_m + 1) % 8;
            ph      = 0;
            valid_m = 1'b1;
        end else if (ph < 7) begin
            ph++;
        end
        clk8_en_i = (ph == 7);
        if (acc_wb) ack_cnt = ack_delay;
        else if (ack_cnt > 0) ack_cnt--;
        wb_ack_i = (ack_cnt == 1);
        if (acc_vid) video_strobe_i = 1'b0;
        if (acc_spi) begin
            if (spi_cont) begin
                spi1_addr_i = spi1_addr_i + 17'd1;
                spi1_data_i = spi1_addr_i[7:0] ^ 8'h5A;
                push_req(1'b0, spi1_addr_i, spi1_data_i, spi1_we_i, -1, 0);
            end else begin
                spi1_strobe_i = 1'b0;
            end
        end
        #1;
        if (chk_grant) check("cpu_grant", 32'(cpu_grant_en_o), 32'(valid_m && cpu_mask[slot_m[2:0]]));
    endtask

    task automatic wait_for(input int s, input int p);
        for (int i = 0; i < 200; i++) begin
            if (slot_m == s && ph == p) break;
            tick();
        end
    endtask

    initial begin
        reset_ni = 1'b0; clk8_en_i = 1'b0; overrun_clr_i = 1'b0;
        spi1_addr_i = 17'h00100; spi1_data_i = 8'h5A; spi1_we_i = 1'b1;
        spi1_cycle_i = 1'b1; spi1_strobe_i = 1'b1;
        video_addr_i = 17'h00000; video_data_i = 8'h00; video_we_i = 1'b0;
        video_cycle_i = 1'b0; video_strobe_i = 1'b0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b1;
        ack_delay = 2; chk_grant = 1'b0; spi_cont = 1'b1; last_vid = 1'b0; n_acc = 0;

        // Reset state, with SPI1 already requesting and an ack on the bus.
        repeat (2) @(posedge sys_clock_i);
        #1;
        check_reset();
        release_reset();
        chk_grant = 1'b1;
        push_req(1'b0, spi1_addr_i, spi1_data_i, spi1_we_i, 1, 0);
        #1;
        check("pre_boundary_stall", 32'(spi1_stall_o), 32'd1);

        // Before the first boundary there is no owner.
        for (int i = 0; i < 7; i++) begin
            tick();
            check("none_stall",  32'(spi1_stall_o), 32'd1);
            check("none_strobe", 32'(wb_strobe_o), 32'd0);
        end
        tick();

        // Continuous SPI1 requests: one strobe in each of slots 1, 2, 3 and 0.
        n_acc = 0;
        repeat (64) tick();
        check("p1_strobes_per_cycle", 32'(n_acc), 32'd4);
        check("p1_no_overrun", 32'(overrun_o), 32'd0);
        spi_cont = 1'b0;
        spi1_strobe_i = 1'b0;
        sb_q.delete();

        // Video and SPI1 both request for slot 0. Video wins slots 0 and 1, and SPI1 waits for slot 2.
        wait_for(7, 0);
        video_cycle_i = 1'b1; video_strobe_i = 1'b1;
        video_addr_i = 17'h1A5A0; video_data_i = 8'hC3; video_we_i = 1'b0;
        push_req(1'b1, 17'h1A5A0, 8'hC3, 1'b0, 0, 0);
        spi1_strobe_i = 1'b1; spi1_addr_i = 17'h0BEEF; spi1_data_i = 8'h3C; spi1_we_i = 1'b1;
        push_req(1'b0, 17'h0BEEF, 8'h3C, 1'b1, 2, 0);
        for (int i = 0; i < 40; i++) begin
            if (slot_m == 2) break;
            tick();
            if (slot_m == 1) video_cycle_i = 1'b0;
            if (slot_m != 2) check("p2_spi_stall", 32'(spi1_stall_o), 32'd1);
        end
        check("p2_spi_stall_open", 32'(spi1_stall_o), 32'd0);
        tick();
        check("p2_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) tick();

        // SPI1 request at pos 4 of slot 2 is held off until slot 3. A 12-clock ack delay then overruns into the CPU slot.
        wait_for(3, 0);
        wait_for(2, 4);
        ack_delay = 12; chk_grant = 1'b0;
        spi1_strobe_i = 1'b1; spi1_addr_i = 17'h12345; spi1_data_i = 8'hA5; spi1_we_i = 1'b0;
        push_req(1'b0, 17'h12345, 8'hA5, 1'b0, 3, 0);
        #1;
        check("p3_stall_guard",  32'(spi1_stall_o), 32'd1);
        check("p3_strobe_guard", 32'(wb_strobe_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (slot_m != 2) break;
            tick();
            if (slot_m == 2) check("p3_stall_hold", 32'(spi1_stall_o), 32'd1);
        end
        check("p3_stall_open", 32'(spi1_stall_o), 32'd0);
        tick();
        repeat (7) tick();
        check("p4_overrun_set",  32'(overrun_o), 32'd1);
        check("p4_grant_held",   32'(cpu_grant_en_o), 32'd0);
        repeat (3) tick();
        check("p4_grant_wait",   32'(cpu_grant_en_o), 32'd0);
        check("p4_no_early_ack", 32'(spi1_ack_o), 32'd0);
        tick();
        check("p4_late_ack",     32'(spi1_ack_o), 32'd1);
        check("p4_grant_at_ack", 32'(cpu_grant_en_o), 32'd0);
        tick();
        check("p4_grant_after",  32'(cpu_grant_en_o), 32'd1);
        check("p4_overrun_sticky", 32'(overrun_o), 32'd1);
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        check("p4_overrun_clr", 32'(overrun_o), 32'd0);
        chk_grant = 1'b1; ack_delay = 2;

        // Ack while idle in a CPU slot is not forwarded.
        wb_ack_i = 1'b1;
        #1;
        check("p6_idle_ack_spi", 32'(spi1_ack_o), 32'd0);
        check("p6_idle_ack_vid", 32'(video_ack_o), 32'd0);
        wb_ack_i = 1'b0;

        // Asynchronous reset in the middle of a transfer.
        wait_for(0, 0);
        ack_delay = 6;
        spi1_strobe_i = 1'b1; spi1_addr_i = 17'h1F00F; spi1_data_i = 8'h96; spi1_we_i = 1'b1;
        push_req(1'b0, 17'h1F00F, 8'h96, 1'b1, 0, 0);
        tick();
        tick();
        tick();
        check("p5_busy_cycle", 32'(wb_cycle_o), 32'd1);
        chk_grant = 1'b0;
        reset_ni = 1'b0;
        wb_ack_i = 1'b1;
        #1;
        check_reset();
        @(posedge sys_clock_i);
        @(posedge sys_clock_i);
        #1;
        release_reset();
        ack_delay = 2; chk_grant = 1'b1;
        sb_q.delete();
        spi1_strobe_i = 1'b1; spi1_addr_i = 17'h00042; spi1_data_i = 8'h24; spi1_we_i = 1'b0;
        push_req(1'b0, 17'h00042, 8'h24, 1'b0, 1, 0);
        #1;
        check("p5_restart_stall", 32'(spi1_stall_o), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("p5_none_stall",  32'(spi1_stall_o), 32'd1);
            check("p5_none_strobe", 32'(wb_strobe_o), 32'd0);
        end
        tick();
        tick();
        repeat (3) tick();

        // Ack while idle in an SPI1 slot, after an SPI1 transfer has completed.
        wb_ack_i = 1'b1;
        #1;
        check("p6_idle_ack_spi_slot", 32'(spi1_ack_o), 32'd0);
        check("p6_idle_ack_vid_slot", 32'(video_ack_o), 32'd0);
        wb_ack_i = 1'b0;
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
